// File: rtl/fifo_n_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared constants and helpers for the fifo_n block.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 32;
  localparam int FIFO_DEFAULT_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // A guarded method fires only when its enable meets its ready.
  function automatic logic fire(input logic ena, input logic rdy);
    return ena & rdy;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_n_if.sv
// ---------------------------------------------------------------------------
// fifo_n_if : enq/deq/first guarded-method bundle between producer, consumer and fifo_n.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fifo_n_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEFAULT_DEPTH
);

  localparam int CNT_W = ptr_w(DEPTH) + 1;

  logic             in_enq__ENA;
  logic [WIDTH-1:0] in_enq_v;
  logic             in_enq__RDY;
  logic             out_deq__ENA;
  logic             out_deq__RDY;
  logic [WIDTH-1:0] out_first;
  logic             out_first__RDY;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_enq__ENA, in_enq_v, out_deq__ENA,
    input  in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, out_count
  );

  modport slave (
    input  in_enq__ENA, in_enq_v, out_deq__ENA,
    output in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, out_count
  );

endinterface

`default_nettype wire

// File: rtl/fifo_n_storage.sv
// ---------------------------------------------------------------------------
// fifo_n_storage : register array, one write port, one async read port, async clear.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_n_storage
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEFAULT_DEPTH,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  wire logic             CLK,
  input  wire logic             nRST,
  input  wire logic             we_i,
  input  wire logic [PTR_W-1:0] waddr_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic [PTR_W-1:0] raddr_i,
  output logic      [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/fifo_n.sv
// ---------------------------------------------------------------------------
// fifo_n   : DEPTH x WIDTH guarded-method FIFO with occupancy count and optional pipeline enq.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_n
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
  parameter int PIPELINE = 0
) (
  input wire logic CLK,
  input wire logic nRST,
  fifo_n_if.slave  bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_not_empty;
  logic w_not_full;
  logic w_enq_rdy;
  logic w_enq_fire;
  logic w_deq_fire;

  assign w_not_empty = (count_q != '0);
  assign w_not_full  = (count_q != C_FULL);

  // Only the pipelined build gets a combinational deq_ENA -> enq_RDY path.
  if (PIPELINE != 0) begin : g_pipe
    assign w_enq_rdy = w_not_full | (bus.out_deq__ENA & w_not_empty);
  end else begin : g_no_pipe
    assign w_enq_rdy = w_not_full;
  end

  assign w_enq_fire = fire(bus.in_enq__ENA, w_enq_rdy);
  assign w_deq_fire = fire(bus.out_deq__ENA, w_not_empty);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_enq_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_deq_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_enq_fire, w_deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_n_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .CLK     (CLK),
    .nRST    (nRST),
    .we_i    (w_enq_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_enq_v),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.out_first)
  );

  assign bus.in_enq__RDY    = w_enq_rdy;
  assign bus.out_deq__RDY   = w_not_empty;
  assign bus.out_first__RDY = w_not_empty;
  assign bus.out_count      = count_q;

  a_count_bound : assert property (@(posedge CLK) disable iff (!nRST)
    count_q <= C_FULL);

  a_ptr_consistent : assert property (@(posedge CLK) disable iff (!nRST)
    (count_q == C_FULL) ? (wr_ptr_q == rd_ptr_q)
                        : (count_q == {1'b0, PTR_W'(wr_ptr_q - rd_ptr_q)}));

endmodule

`default_nettype wire
